// File: rtl/pipelined_adder_unit.sv
// Pipelined add/subtract unit: WIDTH-bit operation split into NSEG = WIDTH/SEG_W
// segments, one segment per stage, carry registered between stages. Upper operand
// segments are skewed forward until their stage; finished low result segments ride
// along so the last stage holds the full result. One op per cycle, global stall.
module pipelined_adder_unit #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSEG = WIDTH / SEG_W;

    // Stage k keeps (k+1) finished result segments; the partial results of all
    // stages are packed back to back in one flat vector.
    function automatic int sum_off(input int k);
        return SEG_W * k * (k + 1) / 2;
    endfunction

    // Stage k keeps the NSEG-1-k operand segments not yet added, packed likewise.
    function automatic int skew_off(input int k);
        return SEG_W * (k * (NSEG - 1) - k * (k - 1) / 2);
    endfunction

    localparam int SUM_BITS  = SEG_W * NSEG * (NSEG + 1) / 2;
    localparam int SKEW_BITS = (NSEG > 1) ? SEG_W * NSEG * (NSEG - 1) / 2 : 1;

    logic                 adv;
    logic [WIDTH-1:0]     b_eff;
    logic                 cin_eff;
    logic [NSEG-1:0]      vld_d, vld_q;
    logic [NSEG-1:0]      cry_d, cry_q;
    logic [SUM_BITS-1:0]  sum_d, sum_q;
    logic [SKEW_BITS-1:0] a_skew_d, a_skew_q;
    logic [SKEW_BITS-1:0] b_skew_d, b_skew_q;
    logic                 ovf_d, ovf_q;
    logic                 zero_d, zero_q;

    // Handshake and operand conditioning: subtract is a + ~b + 1, cin ignored.
    always_comb begin
        adv      = out_ready || !vld_q[NSEG-1];
        in_ready = adv && !rst;
        b_eff    = sub ? ~b : b;
        cin_eff  = sub ? 1'b1 : cin;
    end

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
        localparam int IW = WIDTH - gi * SEG_W;   // operand bits still pending here

        logic [IW-1:0] a_in;
        logic [IW-1:0] b_in;
        logic          c_in;
        logic          v_in;
        logic [SEG_W:0] seg_sum;

        if (gi == 0) begin : g_src_port
            assign a_in = a;
            assign b_in = b_eff;
            assign c_in = cin_eff;
            assign v_in = in_valid && in_ready;
            assign sum_d[sum_off(0) +: SEG_W] = seg_sum[SEG_W-1:0];
        end else begin : g_src_prev
            assign a_in = a_skew_q[skew_off(gi-1) +: IW];
            assign b_in = b_skew_q[skew_off(gi-1) +: IW];
            assign c_in = cry_q[gi-1];
            assign v_in = vld_q[gi-1];
            // Lower finished segments pass through unchanged, this segment on top.
            assign sum_d[sum_off(gi) +: gi*SEG_W]           = sum_q[sum_off(gi-1) +: gi*SEG_W];
            assign sum_d[sum_off(gi) + gi*SEG_W +: SEG_W] = seg_sum[SEG_W-1:0];
        end

        // Segment adder: the lowest pending segment plus the incoming carry.
        assign seg_sum  = {1'b0, a_in[SEG_W-1:0]} + {1'b0, b_in[SEG_W-1:0]}
                        + {{SEG_W{1'b0}}, c_in};
        assign cry_d[gi] = seg_sum[SEG_W];
        assign vld_d[gi] = v_in;

        if (gi < NSEG - 1) begin : g_skew
            assign a_skew_d[skew_off(gi) +: IW-SEG_W] = a_in[IW-1:SEG_W];
            assign b_skew_d[skew_off(gi) +: IW-SEG_W] = b_in[IW-1:SEG_W];
        end else begin : g_flags
            // Carry into the MSB recovered from the MSB sum bit: a ^ b ^ c.
            logic msb_cin;
            assign msb_cin = a_in[SEG_W-1] ^ b_in[SEG_W-1] ^ seg_sum[SEG_W-1];
            assign ovf_d   = msb_cin ^ seg_sum[SEG_W];
            assign zero_d  = (sum_d[sum_off(gi) +: WIDTH] == '0);
        end
    end

    if (NSEG == 1) begin : g_no_skew
        assign a_skew_d = '0;
        assign b_skew_d = '0;
    end

    // Pipeline registers: clear on reset, shift all stages together on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            cry_q    <= '0;
            sum_q    <= '0;
            a_skew_q <= '0;
            b_skew_q <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (adv) begin
            vld_q    <= vld_d;
            cry_q    <= cry_d;
            sum_q    <= sum_d;
            a_skew_q <= a_skew_d;
            b_skew_q <= b_skew_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign out_valid = vld_q[NSEG-1];
    assign out       = sum_q[sum_off(NSEG-1) +: WIDTH];
    assign cout      = cry_q[NSEG-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder_unit.sv
// Bench for pipelined_adder_unit: a 32/16 instance (latency 2) and a 64/16 instance
// (latency 4) checked against a plain-arithmetic reference and a scoreboard.
module tb_pipelined_adder_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [63:0] a_v, b_v;
    logic        cin_v, sub_v;
    logic        in_valid_s [2];
    logic        out_ready_s[2];

    logic        in_ready32, out_valid32, cout32, ovf32, zero32;
    logic [31:0] out32;
    logic        in_ready64, out_valid64, cout64, ovf64, zero64;
    logic [63:0] out64;

    logic        in_ready_s [2];
    logic        out_valid_s[2];
    logic        cout_s[2], ovf_s[2], zero_s[2];
    logic [63:0] out_s[2];

    pipelined_adder_unit #(.WIDTH(32), .SEG_W(16)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready32),
        .a(a_v[31:0]), .b(b_v[31:0]), .cin(cin_v), .sub(sub_v),
        .out_valid(out_valid32), .out_ready(out_ready_s[0]), .out(out32),
        .cout(cout32), .ovf(ovf32), .zero(zero32)
    );

    pipelined_adder_unit #(.WIDTH(64), .SEG_W(16)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready64),
        .a(a_v), .b(b_v), .cin(cin_v), .sub(sub_v),
        .out_valid(out_valid64), .out_ready(out_ready_s[1]), .out(out64),
        .cout(cout64), .ovf(ovf64), .zero(zero64)
    );

    always_comb begin
        in_ready_s[0] = in_ready32;  out_valid_s[0] = out_valid32;
        out_s[0] = {32'd0, out32};   cout_s[0] = cout32; ovf_s[0] = ovf32; zero_s[0] = zero32;
        in_ready_s[1] = in_ready64;  out_valid_s[1] = out_valid64;
        out_s[1] = out64;            cout_s[1] = cout64; ovf_s[1] = ovf64; zero_s[1] = zero64;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int i);
        return (i == 0) ? 32 : 64;
    endfunction

    function automatic int nseg_of(input int i);
        return width_of(i) / 16;
    endfunction

    typedef struct {
        logic [63:0] out;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc_cyc;
        int          acc_stl;
    } exp_t;

    // Reference: wide integer add, carry from bit w, overflow from the sign rule.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        exp_t        r;
        logic [63:0] mask, am, bm;
        logic [64:0] s;
        mask   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        am     = a & mask;
        bm     = (sub ? ~b : b) & mask;
        s      = {1'b0, am} + {1'b0, bm} + {64'd0, (sub ? 1'b1 : cin)};
        r.out  = s[63:0] & mask;
        r.cout = s[w];
        r.ovf  = (am[w-1] == bm[w-1]) && (r.out[w-1] != am[w-1]);
        r.zero = (r.out == 64'd0);
        r.acc_cyc = 0;
        r.acc_stl = 0;
        return r;
    endfunction

    exp_t        sb_q[2][$];
    int          cyc = 0;
    int          stl[2]  = '{0, 0};
    bit          hold[2] = '{0, 0};
    logic [63:0] held_out[2];
    logic [3:0]  held_flg[2];

    // Monitor: sampled mid-cycle, so the values seen are what the next edge uses.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                check($sformatf("rst_in_ready_d%0d", i), 64'(in_ready_s[i]), 64'd0);
                sb_q[i].delete();
                hold[i] = 1'b0;
            end else begin
                check($sformatf("in_ready_d%0d", i), 64'(in_ready_s[i]),
                      64'(!(out_valid_s[i] && !out_ready_s[i])));
                if (hold[i]) begin
                    check($sformatf("hold_out_d%0d", i), out_s[i], held_out[i]);
                    check($sformatf("hold_flags_d%0d", i),
                          64'({out_valid_s[i], cout_s[i], ovf_s[i], zero_s[i]}), 64'(held_flg[i]));
                end
                if (out_valid_s[i] && out_ready_s[i]) begin
                    check($sformatf("sb_nonempty_d%0d", i), 64'(sb_q[i].size() > 0), 64'd1);
                    if (sb_q[i].size() > 0) begin
                        exp_t e;
                        e = sb_q[i].pop_front();
                        check($sformatf("out_d%0d", i), out_s[i], e.out);
                        check($sformatf("cout_d%0d", i), 64'(cout_s[i]), 64'(e.cout));
                        check($sformatf("ovf_d%0d", i), 64'(ovf_s[i]), 64'(e.ovf));
                        check($sformatf("zero_d%0d", i), 64'(zero_s[i]), 64'(e.zero));
                        check($sformatf("latency_d%0d", i), 64'(cyc - e.acc_cyc),
                              64'(nseg_of(i) + stl[i] - e.acc_stl));
                    end
                end
                if (in_valid_s[i] && in_ready_s[i]) begin
                    exp_t e;
                    e = model(width_of(i), a_v, b_v, cin_v, sub_v);
                    e.acc_cyc = cyc;
                    e.acc_stl = stl[i];
                    sb_q[i].push_back(e);
                end
                hold[i]     = out_valid_s[i] && !out_ready_s[i];
                held_out[i] = out_s[i];
                held_flg[i] = {out_valid_s[i], cout_s[i], ovf_s[i], zero_s[i]};
                if (hold[i]) stl[i]++;
            end
        end
    end

    // Present one bundle and hold it until accepted; entered and left at posedge+1.
    task automatic send(input int i, input logic [63:0] a, input logic [63:0] b,
                        input logic c, input logic s, input bit rand_ready);
        a_v = a; b_v = b; cin_v = c; sub_v = s;
        in_valid_s[i] = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (rand_ready) out_ready_s[i] = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready_s[i]) begin
                @(posedge clk); #1;
                in_valid_s[i] = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check($sformatf("accept_timeout_d%0d", i), 64'(in_ready_s[i]), 64'd1);
        in_valid_s[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        for (int t = 0; t < 400 && sb_q[i].size() != 0; t++) begin
            out_ready_s[i] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check($sformatf("drain_d%0d", i), 64'(sb_q[i].size()), 64'd0);
        out_ready_s[i] = 1'b1;
    endtask

    // One op on the 32-bit unit with out_ready high: exact latency 2 and spec values.
    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic c, input logic s, input logic [31:0] eo,
                            input logic ec, input logic ev, input logic ez);
        out_ready_s[0] = 1'b1;
        a_v = {32'd0, a}; b_v = {32'd0, b}; cin_v = c; sub_v = s;
        in_valid_s[0] = 1'b1;
        @(negedge clk);
        check({tag, "_accept"}, 64'(in_ready_s[0]), 64'd1);
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        @(negedge clk);
        check({tag, "_early"}, 64'(out_valid_s[0]), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid_s[0]), 64'd1);
        check({tag, "_out"}, out_s[0], {32'd0, eo});
        check({tag, "_flags"}, 64'({cout_s[0], ovf_s[0], zero_s[0]}), 64'({ec, ev, ez}));
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 64'hFFFF_FFFF_FFFF_FFFF;
            1:       return 64'h0000_0000_0000_0000;
            2:       return 64'h8000_0000_8000_0000;
            3:       return 64'h7FFF_FFFF_7FFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic rand_phase(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid_s[i]  = 1'b0;
                out_ready_s[i] = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            send(i, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
        drain(i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid_s  = '{1'b0, 1'b0};
        out_ready_s = '{1'b0, 1'b0};
        a_v = '0; b_v = '0; cin_v = 1'b0; sub_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_valid_d%0d", i), 64'(out_valid_s[i]), 64'd0);
            check($sformatf("reset_out_d%0d", i), out_s[i], 64'd0);
            check($sformatf("reset_flags_d%0d", i), 64'({cout_s[i], ovf_s[i], zero_s[i]}), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Carry across the segment boundary, overflow, wrap and subtract cases.
        directed("seg_carry", 32'h0000FFFF, 32'd1, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
        directed("add_ovf",   32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        directed("add_wrap",  32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        directed("sub_eq",    32'd5,        32'd5, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
        directed("sub_neg",   32'd3,        32'd5, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_ovf",   32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

        // Eight back-to-back ops with a randomly stalling consumer.
        for (int k = 0; k < 8; k++)
            send(0, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        drain(0);

        // Reset with two ops in flight: nothing stale may come out afterwards.
        out_ready_s[0] = 1'b0;
        send(0, 64'd11, 64'd22, 1'b0, 1'b0, 1'b0);
        send(0, 64'd33, 64'd44, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_flush_valid", 64'(out_valid_s[0]), 64'd0);
        check("rst_flush_out", out_s[0], 64'd0);
        check("rst_flush_flags", 64'({cout_s[0], ovf_s[0], zero_s[0]}), 64'd0);
        @(posedge clk); #1;
        out_ready_s[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_no_stale", 64'(out_valid_s[0]), 64'd0);
            @(posedge clk); #1;
        end
        directed("post_rst", 32'h1234FFFF, 32'h00000001, 1'b1, 1'b0, 32'h12350001, 1'b0, 1'b0, 1'b0);

        // Random traffic on both widths.
        rand_phase(0, 200);
        rand_phase(1, 1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
